// File: rtl/serial_paralelo_if.sv
// Lane-side signals of the RX deserializer: serial bit in, aligned byte out.
interface serial_paralelo_if;
   logic       data_in;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active;

   modport master (output data_in, input data_out, valid_out, active);
   modport slave  (input data_in, output data_out, valid_out, active);
endinterface

// File: rtl/serial_paralelo.sv
// Per-lane RX deserializer: hunts COM alignment bit by bit, locks after
// BC_COUNT boundary-aligned COMs, then strobes out every non-COM byte.
module serial_paralelo #(
   parameter logic [7:0]  COM      = 8'hBC,
   parameter int unsigned BC_COUNT = 4
) (
   input  logic             clk_32f,
   input  logic             reset,
   serial_paralelo_if.slave bus
);

   typedef enum logic [1:0] {SEARCH, SYNC, LOCKED} state_t;

   localparam logic [3:0] BC_LIM = 4'(BC_COUNT);

   state_t     state, state_nxt;
   logic [6:0] sr;
   logic [2:0] bit_cnt, bit_cnt_nxt;
   logic [3:0] com_cnt, com_cnt_nxt;
   logic [7:0] data_q, data_nxt;
   logic       valid_q, valid_nxt;
   logic       active_q, active_nxt;
   logic [7:0] w;
   logic       boundary;

   assign w        = {sr, bus.data_in};
   assign boundary = (bit_cnt == 3'd7);

   assign bus.data_out  = data_q;
   assign bus.valid_out = valid_q;
   assign bus.active    = active_q;

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         state    <= SEARCH;
         sr       <= '0;
         bit_cnt  <= '0;
         com_cnt  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         sr       <= w[6:0];
         bit_cnt  <= bit_cnt_nxt;
         com_cnt  <= com_cnt_nxt;
         data_q   <= data_nxt;
         valid_q  <= valid_nxt;
         active_q <= active_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      com_cnt_nxt = com_cnt;
      data_nxt    = data_q;
      valid_nxt   = 1'b0;
      active_nxt  = active_q;

      case (state)
         SEARCH: begin
            // Bit-slip hunt: every edge is a candidate alignment.
            if (w == COM) begin
               bit_cnt_nxt = '0;
               com_cnt_nxt = 4'd1;
               if (BC_LIM == 4'd1) begin
                  state_nxt  = LOCKED;
                  active_nxt = 1'b1;
               end else begin
                  state_nxt = SYNC;
               end
            end
         end

         SYNC: begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (boundary) begin
               if (w == COM) begin
                  com_cnt_nxt = com_cnt + 4'd1;
                  if (com_cnt + 4'd1 == BC_LIM) begin
                     state_nxt  = LOCKED;
                     active_nxt = 1'b1;
                  end
               end else begin
                  state_nxt   = SEARCH;
                  com_cnt_nxt = '0;
               end
            end
         end

         LOCKED: begin
            // Only reset leaves LOCKED; COM bytes are idle fill and are dropped.
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (boundary && (w != COM)) begin
               data_nxt  = w;
               valid_nxt = 1'b1;
            end
         end

         default: state_nxt = SEARCH;
      endcase
   end

endmodule

// File: tb/tb_serial_paralelo.sv
// Scoreboarded bench for serial_paralelo: directed byte streams with
// hand-computed strobe edges, checked by an independent negedge monitor.
module tb_serial_paralelo;

   typedef struct {
      logic [7:0] data;
      int         edge_no;
   } exp_t;

   logic clk_32f;
   logic reset;
   int   checks;
   int   errors;
   int   edge_n;
   int   lock_edge;
   logic active_q;
   exp_t exp_q[$];

   serial_paralelo_if bus ();

   serial_paralelo #(.COM(8'hBC), .BC_COUNT(4)) dut (
      .clk_32f (clk_32f),
      .reset   (reset),
      .bus     (bus)
   );

   initial clk_32f = 1'b0;
   always #5 clk_32f = ~clk_32f;

   // Edges counted from reset release; edge 1 is the first sampling edge.
   always @(posedge clk_32f or negedge reset) begin
      if (!reset) edge_n <= 0;
      else        edge_n <= edge_n + 1;
   end

   // Monitor: every strobe must match the head of the scoreboard (data and edge).
   always @(negedge clk_32f) begin
      exp_t e;
      if (!reset) begin
         active_q = 1'b0;
      end else begin
         if (bus.valid_out) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_strobe: got data_out=%h at edge %0d, required no strobe",
                        bus.data_out, edge_n);
            end else begin
               e = exp_q.pop_front();
               if (bus.data_out !== e.data || edge_n != e.edge_no) begin
                  errors++;
                  $display("FAIL strobe: got %h at edge %0d, required %h at edge %0d",
                           bus.data_out, edge_n, e.data, e.edge_no);
               end
            end
         end
         if (bus.active && !active_q) lock_edge = edge_n;
         active_q = bus.active;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, got, req);
      end
   endtask

   task automatic send_bit(input logic b);
      bus.data_in = b;
      @(posedge clk_32f);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic expect_byte(input logic [7:0] v, input int e);
      exp_t x;
      x.data    = v;
      x.edge_no = e;
      exp_q.push_back(x);
   endtask

   task automatic apply_reset();
      reset     = 1'b0;
      lock_edge = -1;
      repeat (2) @(posedge clk_32f);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      lock_edge   = -1;
      reset       = 1'b0;
      bus.data_in = 1'b0;

      // Held reset with random serial input
      repeat (5) begin
         bus.data_in = 1'($urandom_range(0, 1));
         @(posedge clk_32f);
         #1;
      end
      check("rst_data_out", 32'(bus.data_out), 32'h00);
      check("rst_valid", 32'(bus.valid_out), 32'h0);
      check("rst_active", 32'(bus.active), 32'h0);
      reset = 1'b1;

      // Clean lock, then data and idle fill while locked
      expect_byte(8'h5A, 40);
      expect_byte(8'hC3, 48);
      expect_byte(8'hAA, 56);
      expect_byte(8'h01, 80);
      repeat (3) send_byte(8'hBC);
      check("no_lock_after_3_com", 32'(bus.active), 32'h0);
      send_byte(8'hBC);
      send_byte(8'h5A);
      check("lock_edge", 32'(lock_edge), 32'd32);
      send_byte(8'hC3);
      send_byte(8'hAA);
      send_byte(8'hBC);
      send_byte(8'hBC);
      check("idle_hold_data", 32'(bus.data_out), 32'hAA);
      send_byte(8'h01);

      // Asynchronous reset mid-byte while locked
      repeat (4) send_bit(1'b1);
      #2;
      reset     = 1'b0;
      lock_edge = -1;
      #1;
      check("async_rst_active", 32'(bus.active), 32'h0);
      check("async_rst_data", 32'(bus.data_out), 32'h00);
      check("async_rst_valid", 32'(bus.valid_out), 32'h0);
      repeat (3) @(posedge clk_32f);
      #1;
      reset = 1'b1;
      expect_byte(8'h3C, 40);
      repeat (3) send_byte(8'hBC);
      check("relock_not_early", 32'(bus.active), 32'h0);
      send_byte(8'hBC);
      send_byte(8'h3C);
      check("relock_edge", 32'(lock_edge), 32'd32);
      send_byte(8'hBC);

      // Misaligned start: junk 101 shifts first COM to complete at edge 11
      apply_reset();
      expect_byte(8'hF0, 43);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      repeat (4) send_byte(8'hBC);
      send_byte(8'hF0);
      check("slip_lock_edge", 32'(lock_edge), 32'd35);
      send_byte(8'hBC);

      // Broken sync: 11 drops back to SEARCH; re-hunt finds COM at edge 32
      apply_reset();
      expect_byte(8'h22, 64);
      send_byte(8'hBC);
      send_byte(8'hBC);
      send_byte(8'h11);
      check("broken_no_active", 32'(bus.active), 32'h0);
      repeat (4) send_byte(8'hBC);
      send_byte(8'h22);
      check("broken_lock_edge", 32'(lock_edge), 32'd56);
      send_byte(8'hBC);

      repeat (3) @(posedge clk_32f);
      #1;
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
